core_batch_scheduler: RTL and testbench

CORE_BATCH_SCHEDULER -- requirements
Module: core_batch_scheduler

---
 rtl/core_batch_scheduler.sv | 174 +++++++++++++++++
 tb/tb_core_batch_scheduler.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/core_batch_scheduler.sv
// rtl/core_batch_scheduler.sv - batch scheduler: load samples, start cores, collect results, reduce to a sum
//
// Ports:
//   clk, reset            single rising-edge clock, synchronous active-high reset
//   sample_in/valid/ready sample stream into per-core slots (accepted only in LOAD)
//   core_sample           packed per-core samples, core i at [i*dataSampleWidth +: dataSampleWidth]
//   core_start            one-cycle start pulse to all cores
//   core_done/result      per-core completion pulse and result (result valid with done)
//   sum_out/overflow      batch sum modulo 2^resultWidth and sticky carry flag
//   sum_valid/ready       output handshake for the batch sum
//   timeout_err           one-cycle pulse when WAIT gives up on the batch
//   busy                  high unless idle in LOAD with no sample buffered
module core_batch_scheduler #(
    parameter int coreCount       = 4,
    parameter int dataSampleWidth = 16,
    parameter int resultWidth     = 32,
    parameter int timeoutCycles   = 1024
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [dataSampleWidth-1:0]           sample_in,
    input  logic                                 sample_valid,
    output logic                                 sample_ready,
    output logic [coreCount*dataSampleWidth-1:0] core_sample,
    output logic [coreCount-1:0]                 core_start,
    input  logic [coreCount-1:0]                 core_done,
    input  logic [coreCount*resultWidth-1:0]     core_result,
    output logic [resultWidth-1:0]               sum_out,
    output logic                                 sum_overflow,
    output logic                                 sum_valid,
    input  logic                                 sum_ready,
    output logic                                 timeout_err,
    output logic                                 busy
);

    localparam int IDX_W = (coreCount > 1) ? $clog2(coreCount) : 1;
    localparam int CNT_W = $clog2(timeoutCycles + 1);
    localparam int K_W   = $clog2(coreCount + 1);

    typedef enum logic [2:0] {
        S_LOAD,
        S_START,
        S_WAIT,
        S_REDUCE,
        S_OUTPUT
    } state_t;

    state_t                               r_state;
    state_t                               w_next_state;
    logic [IDX_W-1:0]                     r_idx;
    logic [coreCount-1:0]                 r_mask;
    logic [resultWidth-1:0]               r_result [coreCount];
    logic [CNT_W-1:0]                     r_wait_cnt;
    logic [K_W-1:0]                       r_k;
    logic [resultWidth-1:0]               r_acc;
    logic                                 r_acc_ovf;
    logic [resultWidth-1:0]               r_sum;
    logic                                 r_sum_ovf;
    logic [coreCount*dataSampleWidth-1:0] r_core_sample;

    logic                                 w_accept;
    logic                                 w_last_sample;
    logic [coreCount-1:0]                 w_mask_next;
    logic                                 w_all_done;
    logic                                 w_timeout;
    logic                                 w_reduce_last;
    logic [resultWidth-1:0]               w_addend;
    logic [resultWidth:0]                 w_sum_ext;

    assign w_accept      = (r_state == S_LOAD) && sample_valid;
    assign w_last_sample = w_accept && (r_idx == IDX_W'(coreCount - 1));
    // Mask including this cycle's captures; repeated done bits are harmless here.
    assign w_mask_next   = r_mask | core_done;
    assign w_all_done    = &w_mask_next;
    // Completion in the final WAIT cycle wins over timeout.
    assign w_timeout     = (r_state == S_WAIT) && !w_all_done &&
                           (r_wait_cnt == CNT_W'(timeoutCycles - 1));
    // REDUCE spends coreCount cycles adding, then one cycle committing the sum.
    assign w_reduce_last = (r_k == K_W'(coreCount));

    always_comb begin
        w_addend = '0;
        for (int i = 0; i < coreCount; i++) begin
            if (r_k == K_W'(i)) begin
                w_addend = r_result[i];
            end
        end
    end

    assign w_sum_ext = {1'b0, r_acc} + {1'b0, w_addend};

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_LOAD:   if (w_last_sample) w_next_state = S_START;
            S_START:  w_next_state = S_WAIT;
            S_WAIT: begin
                if (w_all_done)     w_next_state = S_REDUCE;
                else if (w_timeout) w_next_state = S_LOAD;
            end
            S_REDUCE: if (w_reduce_last) w_next_state = S_OUTPUT;
            S_OUTPUT: if (sum_ready) w_next_state = S_LOAD;
            default:  w_next_state = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_LOAD;
            r_idx         <= '0;
            r_mask        <= '0;
            r_wait_cnt    <= '0;
            r_k           <= '0;
            r_acc         <= '0;
            r_acc_ovf     <= 1'b0;
            r_sum         <= '0;
            r_sum_ovf     <= 1'b0;
            r_core_sample <= '0;
            for (int i = 0; i < coreCount; i++) r_result[i] <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_LOAD: begin
                    if (w_accept) begin
                        r_core_sample[r_idx*dataSampleWidth +: dataSampleWidth] <= sample_in;
                        r_idx <= w_last_sample ? '0 : r_idx + IDX_W'(1);
                    end
                end
                S_START: begin
                    r_mask     <= '0;
                    r_wait_cnt <= '0;
                    r_k        <= '0;
                    r_acc      <= '0;
                    r_acc_ovf  <= 1'b0;
                    r_sum      <= '0;
                    r_sum_ovf  <= 1'b0;
                    for (int i = 0; i < coreCount; i++) r_result[i] <= '0;
                end
                S_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    r_mask     <= w_mask_next;
                    for (int i = 0; i < coreCount; i++) begin
                        if (core_done[i] && !r_mask[i]) begin
                            r_result[i] <= core_result[i*resultWidth +: resultWidth];
                        end
                    end
                    if (w_timeout) r_idx <= '0;
                end
                S_REDUCE: begin
                    if (!w_reduce_last) begin
                        r_acc     <= w_sum_ext[resultWidth-1:0];
                        r_acc_ovf <= r_acc_ovf | w_sum_ext[resultWidth];
                        r_k       <= r_k + K_W'(1);
                    end else begin
                        r_sum     <= r_acc;
                        r_sum_ovf <= r_acc_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

    // Combinational outputs are forced low while reset is held.
    assign sample_ready = !reset && (r_state == S_LOAD);
    assign core_start   = {coreCount{!reset && (r_state == S_START)}};
    assign sum_valid    = !reset && (r_state == S_OUTPUT);
    assign timeout_err  = !reset && w_timeout;
    assign busy         = !reset && !((r_state == S_LOAD) && (r_idx == '0));
    assign core_sample  = r_core_sample;
    assign sum_out      = r_sum;
    assign sum_overflow = r_sum_ovf;

endmodule

// File: tb/tb_core_batch_scheduler.sv
// tb/tb_core_batch_scheduler.sv - directed self-checking bench for core_batch_scheduler
module tb_core_batch_scheduler;

    logic         clk;
    logic         reset;
    logic [15:0]  sample_in;
    logic         sample_valid;
    logic         sample_ready;
    logic [63:0]  core_sample;
    logic [3:0]   core_start;
    logic [3:0]   core_done;
    logic [127:0] core_result;
    logic [31:0]  sum_out;
    logic         sum_overflow;
    logic         sum_valid;
    logic         sum_ready;
    logic         timeout_err;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    core_batch_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .core_sample  (core_sample),
        .core_start   (core_start),
        .core_done    (core_done),
        .core_result  (core_result),
        .sum_out      (sum_out),
        .sum_overflow (sum_overflow),
        .sum_valid    (sum_valid),
        .sum_ready    (sum_ready),
        .timeout_err  (timeout_err),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send4(input logic [63:0] v);
        for (int k = 0; k < 4; k++) begin
            sample_in    = v[k*16 +: 16];
            sample_valid = 1'b1;
            step();
        end
        sample_valid = 1'b0;
    endtask

    task automatic pulse_done(input logic [3:0] mask, input logic [127:0] res);
        core_done   = mask;
        core_result = res;
        step();
        core_done   = '0;
        core_result = '0;
    endtask

    task automatic consume();
        sum_ready = 1'b1;
        step();
        sum_ready = 1'b0;
    endtask

    initial begin
        logic bad;
        reset        = 1'b1;
        sample_in    = '0;
        sample_valid = 1'b0;
        core_done    = '0;
        core_result  = '0;
        sum_ready    = 1'b0;

        // Reset state
        step(); step();
        @(negedge clk);
        check("rst_sample_ready", sample_ready, 0);
        check("rst_core_sample", core_sample, 0);
        check("rst_sum_out", sum_out, 0);
        check("rst_sum_valid", sum_valid, 0);
        check("rst_core_start", core_start, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout", timeout_err, 0);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", sample_ready, 1);
        check("post_rst_busy", busy, 0);

        // Load 1..4, one sample then check busy mid-load
        sample_in = 16'h0001; sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        @(negedge clk);
        check("midload_busy", busy, 1);
        check("midload_ready", sample_ready, 1);
        check("midload_start", core_start, 0);
        step();
        for (int k = 2; k <= 4; k++) begin
            sample_in = 16'(k); sample_valid = 1'b1;
            step();
        end
        sample_valid = 1'b0;
        @(negedge clk);
        check("start_pulse", core_start, 4'hf);
        check("load1_samples", core_sample, 64'h0004_0003_0002_0001);
        check("start_ready", sample_ready, 0);
        check("start_busy", busy, 1);
        step();
        @(negedge clk);
        check("start_one_cycle", core_start, 0);

        // Results 10,20,30,40, done order core2, core0, core3, core1
        pulse_done(4'b0100, {32'd0, 32'd30, 32'd0, 32'd0});
        pulse_done(4'b0001, {32'd0, 32'd0, 32'd0, 32'd10});
        pulse_done(4'b1000, {32'd40, 32'd0, 32'd0, 32'd0});
        pulse_done(4'b0010, {32'd0, 32'd0, 32'd20, 32'd0});
        step(); step(); step(); step();
        @(negedge clk);
        check("lat_not_early", sum_valid, 0);
        step();
        @(negedge clk);
        check("lat_valid", sum_valid, 1);
        check("sum_100", sum_out, 100);
        check("ovf_100", sum_overflow, 0);

        // Back-pressure for 10 cycles with sample_valid high
        sample_in = 16'hBEEF; sample_valid = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            @(negedge clk);
            if (sum_valid !== 1'b1 || sum_out !== 32'd100 || sample_ready !== 1'b0) bad = 1'b1;
        end
        sample_valid = 1'b0;
        check("hold_output", bad, 0);
        check("hold_no_accept", core_sample, 64'h0004_0003_0002_0001);
        step();
        consume();
        @(negedge clk);
        check("consume_valid", sum_valid, 0);
        check("consume_ready", sample_ready, 1);
        check("consume_busy", busy, 0);

        // Overflow batch with a duplicate done on core0
        send4(64'h0008_0007_0006_0005);
        step();
        @(negedge clk);
        check("load2_samples", core_sample, 64'h0008_0007_0006_0005);
        check("start_cleared_sum", sum_out, 0);
        step();
        pulse_done(4'b0001, {96'd0, 32'hFFFF_FFFF});
        pulse_done(4'b0001, {96'd0, 32'd5});
        pulse_done(4'b0010, {64'd0, 32'd1, 32'd0});
        pulse_done(4'b1100, 128'd0);
        step(); step(); step(); step(); step();
        @(negedge clk);
        check("ovf_valid", sum_valid, 1);
        check("ovf_sum", sum_out, 0);
        check("ovf_flag", sum_overflow, 1);
        consume();

        // Timeout: core3 never completes
        send4(64'h0004_0003_0002_0001);
        step();
        pulse_done(4'b0001, {96'd0, 32'd1});
        pulse_done(4'b0010, {64'd0, 32'd2, 32'd0});
        pulse_done(4'b0100, {32'd0, 32'd3, 64'd0});
        bad = 1'b0;
        for (int n = 4; n < 1024; n++) begin
            @(negedge clk);
            if (timeout_err !== 1'b0 || sum_valid !== 1'b0) bad = 1'b1;
            step();
        end
        @(negedge clk);
        check("to_no_early", bad, 0);
        check("to_pulse", timeout_err, 1);
        check("to_no_valid", sum_valid, 0);
        step();
        @(negedge clk);
        check("to_one_cycle", timeout_err, 0);
        check("to_ready", sample_ready, 1);
        check("to_busy", busy, 0);

        // Reset mid-WAIT, then a clean batch
        send4(64'h000C_000B_000A_0009);
        step();
        pulse_done(4'b0010, {64'd0, 32'd7, 32'd0});
        step(); step();
        reset = 1'b1;
        step();
        @(negedge clk);
        check("midrst_ready", sample_ready, 0);
        check("midrst_core_sample", core_sample, 0);
        check("midrst_timeout", timeout_err, 0);
        check("midrst_busy", busy, 0);
        check("midrst_sum_valid", sum_valid, 0);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("midrst_after_ready", sample_ready, 1);
        send4(64'h0040_0030_0020_0010);
        @(negedge clk);
        check("newbatch_start", core_start, 4'hf);
        check("newbatch_samples", core_sample, 64'h0040_0030_0020_0010);
        step();
        pulse_done(4'b1111, {32'd4, 32'd3, 32'd2, 32'd1});
        step(); step(); step(); step(); step();
        @(negedge clk);
        check("newbatch_valid", sum_valid, 1);
        check("newbatch_sum", sum_out, 10);
        check("newbatch_ovf", sum_overflow, 0);
        consume();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
